pam4_tx: RTL and testbench

PAM4_TX -- requirements
Module: pam4_tx

---
 rtl/pam4_pkg.sv | 15 +
 rtl/prbs7_gen.sv | 18 +
 rtl/pam4_tx.sv | 73 +++++++
 tb/tb_pam4_tx.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/pam4_pkg.sv
// pam4_pkg: shared PAM4 state type, level constants, Gray-to-level map and FFE tap
package pam4_pkg;
  typedef enum logic [1:0] {IDLE, PREAMBLE, PAYLOAD} state_t;
  localparam int LVL_OUTER = 96;
  localparam int LVL_INNER = 32;
  function automatic logic signed [7:0] gray_level(input logic [1:0] s, input int outer, input int inner);
    return 8'(s == 2'b00 ? -outer : s == 2'b01 ? -inner : s == 2'b11 ? inner : outer);
  endfunction
  // a - (p >>> 2), widened so the subtraction cannot wrap before saturation
  function automatic logic signed [7:0] ffe_tap(input logic signed [7:0] a, input logic signed [7:0] p);
    logic signed [9:0] d;
    d = {{2{a[7]}}, a} - {{4{p[7]}}, p[7:2]};
    return d > 10'sd127 ? 8'sh7F : d < -10'sd128 ? 8'sh80 : d[7:0];
  endfunction
endpackage

// File: rtl/prbs7_gen.sv
// prbs7_gen: x^7+x^6+1 LFSR yielding two bits per symbol, first bit in the MSB
// Ports: clk, rst (async, active-high), clear (sync reseed to 7'h7F),
//        advance (consume current symbol), sym (2-bit symbol available now)
module prbs7_gen (
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       advance,
  output logic [1:0] sym
);
  logic [6:0] s;
  // two Fibonacci steps computed at once; s[6] holds the oldest bit
  assign sym = {s[6] ^ s[5], s[5] ^ s[4]};
  always_ff @(posedge clk or posedge rst)
    if (rst) s <= 7'h7F;
    else if (clear) s <= 7'h7F;
    else if (advance) s <= {s[4:0], sym};
endmodule

// File: rtl/pam4_tx.sv
// pam4_tx: PAM4 transmitter emitting a +/-3 preamble then Gray-mapped payload with PRBS7 fill
// Ports: clk, rst (async, active-high), enable, sym_in[1:0], sym_valid, sym_ready,
//        tx_data[7:0] signed sample, sym_strobe, busy, underflow (sticky)
// Option: define PAM4_TX_FFE_EN for a one-tap de-emphasis a[n] - (a[n-1]>>>2), saturated
module pam4_tx import pam4_pkg::*; #(
  parameter int OSR          = 4,
  parameter int PREAMBLE_LEN = 32,
  parameter int AMP_OUTER    = LVL_OUTER,
  parameter int AMP_INNER    = LVL_INNER
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic [1:0]        sym_in,
  input  logic              sym_valid,
  output logic              sym_ready,
  output logic signed [7:0] tx_data,
  output logic              sym_strobe,
  output logic              busy,
  output logic              underflow
);
  localparam int PW = $clog2(OSR);
  state_t state;
  logic [PW-1:0] phase;
  logic [7:0] pre_cnt;
  logic [1:0] prbs_sym;
  logic sym_end, start, load, stop, slot, fill;
  logic signed [7:0] nxt_lvl, tx_next;
  assign sym_end = state != IDLE && phase == PW'(OSR - 1);
  assign start = state == IDLE && enable;
  assign load = start || (sym_end && enable);
  assign stop = sym_end && !enable;
  // a payload slot opens at the end of the last preamble symbol and every payload symbol
  assign slot = sym_end && enable && (state == PAYLOAD || pre_cnt == 8'(PREAMBLE_LEN - 1));
  assign fill = slot && !sym_valid;
  assign sym_ready = slot;
  assign busy = state != IDLE;
  assign nxt_lvl = start ? 8'(AMP_OUTER) :
                   !slot ? (pre_cnt[0] ? 8'(AMP_OUTER) : 8'(-AMP_OUTER)) :
                   gray_level(sym_valid ? sym_in : prbs_sym, AMP_OUTER, AMP_INNER);
  prbs7_gen u_prbs (
    .clk     (clk),
    .rst     (rst),
    .clear   (state == IDLE),
    .advance (fill),
    .sym     (prbs_sym)
  );
`ifdef PAM4_TX_FFE_EN
  logic signed [7:0] hist;
  assign tx_next = ffe_tap(nxt_lvl, hist);
  always_ff @(posedge clk or posedge rst)
    if (rst) hist <= '0;
    else hist <= load ? nxt_lvl : (state == IDLE || stop) ? '0 : hist;
`else
  assign tx_next = nxt_lvl;
`endif
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state      <= IDLE;
      phase      <= '0;
      pre_cnt    <= '0;
      tx_data    <= '0;
      sym_strobe <= 1'b0;
      underflow  <= 1'b0;
    end else begin
      phase      <= (state == IDLE || phase == PW'(OSR - 1)) ? '0 : phase + 1'b1;
      sym_strobe <= load;
      tx_data    <= load ? tx_next : stop ? '0 : tx_data;
      underflow  <= start ? 1'b0 : underflow | fill;
      pre_cnt    <= start ? '0 : load ? pre_cnt + 8'd1 : pre_cnt;
      state      <= start ? PREAMBLE : stop ? IDLE : slot ? PAYLOAD : state;
    end
endmodule

// File: tb/tb_pam4_tx.sv
// tb_pam4_tx: randomized and directed self-checking bench for pam4_tx against a symbol-level model
module tb_pam4_tx;
  localparam int OSR = 4;
  localparam int PL = 4;
  logic clk = 0, rst, enable, sym_valid, sym_ready, sym_strobe, busy, underflow;
  logic [1:0] sym_in;
  logic signed [7:0] tx_data;
  int checks = 0, failures = 0;
  int tab[4] = '{-96, -32, 96, 32};
  int pre_exp[4] = '{96, -96, 96, -96};
  bit seq[0:4095];
  bit m_on, m_strobe, m_uf;
  int t, k, pi, m_tx, m_prev, held;
  bit found;

  pam4_tx #(.OSR(OSR), .PREAMBLE_LEN(PL)) dut (
    .clk(clk), .rst(rst), .enable(enable), .sym_in(sym_in), .sym_valid(sym_valid),
    .sym_ready(sym_ready), .tx_data(tx_data), .sym_strobe(sym_strobe), .busy(busy),
    .underflow(underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int exp_tx(input int a, input int p);
`ifdef PAM4_TX_FFE_EN
    int d;
    d = a - (p - (((p % 4) + 4) % 4)) / 4;
    return d > 127 ? 127 : d < -128 ? -128 : d;
`else
    return a;
`endif
  endfunction

  function automatic int prbs_next();
    int v;
    v = 2 * seq[pi] + seq[pi + 1];
    pi += 2;
    return v;
  endfunction

  task automatic load(input int lvl);
    m_tx = exp_tx(lvl, m_prev);
    m_prev = lvl;
  endtask

  // symbol-level model: t counts cycles since the transmission started
  always @(posedge clk or posedge rst)
    if (rst) begin
      m_on = 0; m_strobe = 0; m_uf = 0; m_tx = 0; m_prev = 0; t = 0; pi = 7;
    end else if (!m_on) begin
      m_strobe = enable;
      if (enable) begin
        m_on = 1; t = 0; m_uf = 0; pi = 7; m_prev = 0; load(96);
      end
    end else if (t % OSR == OSR - 1) begin
      m_strobe = enable;
      if (!enable) begin
        m_on = 0; m_tx = 0; m_prev = 0;
      end else begin
        k = t / OSR + 1;
        t++;
        if (k < PL) load(k % 2 ? -96 : 96);
        else if (sym_valid) load(tab[sym_in]);
        else begin
          load(tab[prbs_next()]);
          m_uf = 1;
        end
      end
    end else begin
      m_strobe = 0;
      t++;
    end

  always @(negedge clk)
    if (!rst) begin
      chk("tx_data", tx_data, m_tx);
      chk("sym_strobe", sym_strobe, m_strobe);
      chk("busy", busy, m_on);
      chk("underflow", underflow, m_uf);
      chk("sym_ready", sym_ready, m_on && t % OSR == OSR - 1 && enable && t / OSR + 1 >= PL);
    end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] s, input logic v, input int exp_lvl, input int exp_uf);
    sym_in = s;
    sym_valid = v;
    found = 0;
    for (int i = 0; i < 64 && !found; i++) begin
      @(negedge clk);
      found = sym_ready;
    end
    chk("ready_seen", found, 1);
    tick();
    sym_valid = 0;
`ifndef PAM4_TX_FFE_EN
    chk("payload_level", tx_data, exp_lvl);
`endif
    chk("payload_strobe", sym_strobe, 1);
    chk("payload_underflow", underflow, exp_uf);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 7; i++) seq[i] = 1;
    for (int i = 7; i < 4096; i++) seq[i] = seq[i - 7] ^ seq[i - 6];
    rst = 1; enable = 0; sym_valid = 0; sym_in = 0;
    repeat (3) tick();
    chk("reset_tx", tx_data, 0);
    chk("reset_busy", busy, 0);
    chk("reset_strobe", sym_strobe, 0);
    chk("reset_underflow", underflow, 0);
    rst = 0;
    tick();
    chk("idle_tx", tx_data, 0);
    enable = 1;
    tick();
    for (int i = 0; i < 16; i++) begin
`ifndef PAM4_TX_FFE_EN
      chk("preamble_level", tx_data, pre_exp[i / 4]);
`endif
      chk("preamble_strobe", sym_strobe, i % 4 == 0);
      chk("preamble_busy", busy, 1);
      if (i < 15) tick();
    end
    send(2'b00, 1, -96, 0);
    send(2'b01, 1, -32, 0);
    send(2'b11, 1, 32, 0);
    send(2'b10, 1, 96, 0);
    send(2'b11, 0, -96, 1);
    for (int i = 0; i < 400; i++) begin
      enable = $urandom_range(0, 19) != 0;
      sym_valid = $urandom_range(0, 3) != 0;
      sym_in = 2'($urandom_range(0, 3));
      tick();
    end
    enable = 1;
    sym_valid = 1;
    found = 0;
    for (int i = 0; i < 64 && !found; i++) begin
      tick();
      found = sym_strobe && busy;
    end
    chk("strobe_seen", found, 1);
    held = tx_data;
    tick();
    enable = 0;
    tick();
    chk("drop_hold_p2", tx_data, held);
    chk("drop_busy_p2", busy, 1);
    tick();
    chk("drop_hold_p3", tx_data, held);
    tick();
    chk("drop_tx_zero", tx_data, 0);
    chk("drop_busy_zero", busy, 0);
    chk("drop_ready_zero", sym_ready, 0);
    tick();
    enable = 1;
    tick();
    chk("restart_level", tx_data, 96);
    chk("restart_strobe", sym_strobe, 1);
    for (int i = 0; i < 40; i++) begin
      sym_valid = $urandom_range(0, 1);
      sym_in = 2'($urandom_range(0, 3));
      tick();
    end
    #2;
    rst = 1;
    #1;
    chk("async_tx", tx_data, 0);
    chk("async_strobe", sym_strobe, 0);
    chk("async_busy", busy, 0);
    chk("async_underflow", underflow, 0);
    chk("async_ready", sym_ready, 0);
    tick();
    rst = 0;
    enable = 0;
    repeat (3) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
